// File: rtl/fetch_pc_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_queue_if
// Brief    : Redirect, imem request/response and decode-side channels of the
//            fetch unit. The master modport is the fetch unit itself.
//            FETCH_MISALIGN_TRAP_EN adds the misalign_err status signal.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_queue_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic            redirect_mode;
    logic [XLEN-1:0] redirect_base;
    logic [XLEN-1:0] redirect_imm;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] fetch_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_err;
`endif

    modport master (
        input  redirect_valid, redirect_mode, redirect_base, redirect_imm,
               imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
               fetch_pc
`ifdef FETCH_MISALIGN_TRAP_EN
               , misalign_err
`endif
    );

    modport slave (
        output redirect_valid, redirect_mode, redirect_base, redirect_imm,
               imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
               fetch_pc
`ifdef FETCH_MISALIGN_TRAP_EN
               , misalign_err
`endif
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_queue
// Brief    : Instruction fetch unit. Owns the PC, issues one word fetch at a
//            time over a valid/ready request channel and queues returned
//            {pc, instr} pairs for decode. Redirects flush the queue and
//            discard any in-flight stale fetch.
//            Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect
//            targets raise misalign_err and halt fetch instead of being
//            silently aligned.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    fetch_pc_queue_if.master bus
);
    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(DEPTH);

    typedef logic [c_PTR_W-1:0] ptr_t;
    typedef logic [c_PTR_W:0]   cnt_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT     = 3'd2,
        KILL_REQ = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_req_valid;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    ptr_t            r_wr_ptr;
    ptr_t            r_rd_ptr;
    cnt_t            r_count;

    logic            w_flush;
    logic            w_req_hs;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic            w_pc_inc;
    logic            w_out_valid;
    logic            w_fetch_hold;
    cnt_t            w_cnt_after_push;
    logic [XLEN-1:0] w_target_raw;
    logic [XLEN-1:0] w_target;

    assign w_target_raw = bus.redirect_mode ? (bus.redirect_base + bus.redirect_imm)
                                            : bus.redirect_base;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    // Unaligned targets are kept as-is so software can see the faulting PC.
    assign w_target         = w_target_raw;
    assign w_fetch_hold     = r_misalign;
    assign bus.misalign_err = r_misalign;

    // Every redirect re-evaluates the alignment of its target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (w_flush) begin
            r_misalign <= (w_target_raw[1:0] != 2'b00);
        end
    end
`else
    assign w_target     = w_target_raw & ~XLEN'(3);
    assign w_fetch_hold = 1'b0;
`endif

    assign w_flush          = bus.redirect_valid;
    assign w_req_hs         = r_req_valid && bus.imem_req_ready;
    assign w_out_valid      = (r_count != '0);
    assign w_pop            = w_out_valid && bus.out_ready;
    assign w_cnt_after_push = r_count + cnt_t'(1) - cnt_t'(w_pop);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle strobes; a redirect overrides normal progress.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_pc_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_flush && (r_count < c_DEPTH) && !w_fetch_hold) begin
                    w_state_nxt = REQ;
                    w_issue     = 1'b1;
                end
            end
            REQ: begin
                if (bus.imem_req_ready) begin
                    w_pc_inc    = !w_flush;
                    w_state_nxt = w_flush ? DRAIN : WAIT;
                end else if (w_flush) begin
                    w_state_nxt = KILL_REQ;
                end
            end
            WAIT: begin
                if (w_flush) begin
                    w_state_nxt = bus.imem_rsp_valid ? IDLE : DRAIN;
                end else if (bus.imem_rsp_valid) begin
                    w_push = 1'b1;
                    if (w_cnt_after_push < c_DEPTH) begin
                        w_state_nxt = REQ;
                        w_issue     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            KILL_REQ: begin
                if (bus.imem_req_ready) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_rsp_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Program counter: redirect target, else advance on an accepted live fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (w_flush) begin
            r_pc <= w_target;
        end else if (w_pc_inc) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + XLEN'(4);
        end
    end

    // Request channel: address latched on issue, held until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
        end else if (w_issue) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= r_pc;
        end else if (w_req_hs) begin
            r_req_valid <= 1'b0;
        end
    end

    // Fetch FIFO: flush beats both push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= r_req_pc;
                r_instr_mem[r_wr_ptr] <= bus.imem_rsp_data;
                r_wr_ptr              <= r_wr_ptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + cnt_t'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - cnt_t'(1);
            end
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_req_addr;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_pc         = r_pc_mem[r_rd_ptr];
    assign bus.out_instr      = r_instr_mem[r_rd_ptr];
    assign bus.fetch_pc       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_queue
// Brief    : Scoreboard bench for fetch_pc_queue (RESET_PC=0x100, DEPTH=2).
//            Instruction memory returns addr ^ 0xA5A50000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_queue;
    localparam int XLEN = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_pc_queue_if #(.XLEN(XLEN)) bus ();

    fetch_pc_queue #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0100),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_req     = 0;
    int          n_out     = 0;
    int          rsp_delay = 1;
    logic [31:0] exp_req[$];
    logic [63:0] exp_out[$];
    logic [31:0] rsp_addr;
    logic [63:0] out_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req(input int tgt, input string name);
        int i = 0;
        while (n_req < tgt && i < 300) begin
            @(negedge clk); #1; i++;
        end
        check(name, n_req, (n_req < tgt) ? tgt : n_req);
    endtask

    task automatic wait_out(input int tgt, input string name);
        int i = 0;
        while (n_out < tgt && i < 300) begin
            @(negedge clk); #1; i++;
        end
        check(name, n_out, (n_out < tgt) ? tgt : n_out);
    endtask

    task automatic do_reset;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic redirect(input logic mode, input logic [31:0] base, input logic [31:0] imm);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_mode  = mode;
        bus.redirect_base  = base;
        bus.redirect_imm   = imm;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
    endtask

    // Request monitor: every accepted fetch address is matched in order.
    always @(negedge clk) begin
        if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
            n_req++;
            if (exp_req.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL req_extra: got addr %h expected no request", bus.imem_req_addr);
            end else begin
                check("req_addr", bus.imem_req_addr, exp_req.pop_front());
            end
        end
    end

    // Output monitor: every consumed {pc, instr} is matched in order.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_out.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_extra: got pc %h expected no output", bus.out_pc);
            end else begin
                out_e = exp_out.pop_front();
                check("out_pc", bus.out_pc, out_e[63:32]);
                check("out_instr", bus.out_instr, out_e[31:0]);
            end
        end
    end

    // Instruction memory: answers each accepted request after rsp_delay cycles.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
                rsp_addr = bus.imem_req_addr;
                @(posedge clk);
                repeat (rsp_delay - 1) @(posedge clk);
                #1;
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = rsp_addr ^ 32'hA5A5_0000;
                @(posedge clk); #1;
                bus.imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_mode  = 1'b0;
        bus.redirect_base  = '0;
        bus.redirect_imm   = '0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;

        // Streaming from reset with decode always ready.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_req_addr", bus.imem_req_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_fetch_pc", bus.fetch_pc, 32'h100);
        exp_req.push_back(32'h100); exp_req.push_back(32'h104); exp_req.push_back(32'h108);
        exp_req.push_back(32'h10C); exp_req.push_back(32'h110);
        exp_out.push_back({32'h100, 32'hA5A5_0100});
        exp_out.push_back({32'h104, 32'hA5A5_0104});
        exp_out.push_back({32'h108, 32'hA5A5_0108});
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("lat_req_valid_c1", bus.imem_req_valid, 0);
        @(negedge clk);
        check("lat_req_valid_c2", bus.imem_req_valid, 1);
        check("lat_req_addr_c2", bus.imem_req_addr, 32'h100);
        wait_out(3, "stream_timeout");
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("stream_hold_req_valid", bus.imem_req_valid, 0);
        check("stream_hold_out_pc", bus.out_pc, 32'h10C);
        check("stream_hold_out_instr", bus.out_instr, 32'hA5A5_010C);
        check("stream_req_queue", exp_req.size(), 0);

        // Decode stalled from reset: two fetches fill the FIFO, then resume.
        exp_req.push_back(32'h100); exp_req.push_back(32'h104);
        do_reset();
        repeat (12) @(negedge clk);
        check("full_req_valid", bus.imem_req_valid, 0);
        check("full_out_valid", bus.out_valid, 1);
        check("full_out_pc", bus.out_pc, 32'h100);
        check("full_out_instr", bus.out_instr, 32'hA5A5_0100);
        check("full_req_queue", exp_req.size(), 0);
        exp_out.push_back({32'h100, 32'hA5A5_0100});
        exp_out.push_back({32'h104, 32'hA5A5_0104});
        exp_out.push_back({32'h108, 32'hA5A5_0108});
        exp_req.push_back(32'h108); exp_req.push_back(32'h10C); exp_req.push_back(32'h110);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_out(6, "resume_timeout");
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("resume_req_queue", exp_req.size(), 0);
        check("resume_out_queue", exp_out.size(), 0);

        // Request stalled by imem, absolute redirect while pending.
        bus.imem_req_ready = 1'b0;
        exp_req.push_back(32'h100); exp_req.push_back(32'h200); exp_req.push_back(32'h204);
        do_reset();
        @(negedge clk);
        @(negedge clk);
        check("stall_valid_c2", bus.imem_req_valid, 1);
        check("stall_addr_c2", bus.imem_req_addr, 32'h100);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_valid_hold", bus.imem_req_valid, 1);
            check("stall_addr_hold", bus.imem_req_addr, 32'h100);
        end
        redirect(1'b0, 32'h200, 32'h0);
        @(negedge clk);
        check("kill_valid_hold", bus.imem_req_valid, 1);
        check("kill_addr_hold", bus.imem_req_addr, 32'h100);
        check("kill_fetch_pc", bus.fetch_pc, 32'h200);
        @(posedge clk); #1 bus.imem_req_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("kill_out_pc", bus.out_pc, 32'h200);
        check("kill_out_instr", bus.out_instr, 32'hA5A5_0200);
        check("kill_fetch_pc_after", bus.fetch_pc, 32'h208);
        check("kill_req_queue", exp_req.size(), 0);

        // Relative redirect while waiting on a slow response, FIFO non-empty.
        rsp_delay = 2;
        exp_req.push_back(32'h100); exp_req.push_back(32'h104);
        exp_req.push_back(32'hFF8); exp_req.push_back(32'hFFC);
        do_reset();
        wait_req(n_req + 2, "rel_timeout");
        check("rel_pre_out_valid", bus.out_valid, 1);
        check("rel_pre_out_pc", bus.out_pc, 32'h100);
        redirect(1'b1, 32'h1000, 32'hFFFF_FFF8);
        @(negedge clk);
        check("rel_flush_out_valid", bus.out_valid, 0);
        repeat (20) @(negedge clk);
        check("rel_out_pc", bus.out_pc, 32'hFF8);
        check("rel_out_instr", bus.out_instr, 32'hA5A5_0FF8);
        check("rel_req_queue", exp_req.size(), 0);
        rsp_delay = 1;

        // Sequential wrap past the top of the address space.
        exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0000_0000);
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_mode  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        bus.redirect_base  = 32'hFFFF_FFFC;
`else
        bus.redirect_base  = 32'hFFFF_FFFF;
`endif
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_out_instr", bus.out_instr, 32'h5A5A_FFFC);
        check("wrap_fetch_pc", bus.fetch_pc, 32'h0000_0004);
        check("wrap_req_queue", exp_req.size(), 0);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect halts fetch until an aligned redirect.
        redirect(1'b0, 32'h202, 32'h0);
        repeat (10) @(negedge clk);
        check("mis_err_set", bus.misalign_err, 1);
        check("mis_req_valid", bus.imem_req_valid, 0);
        check("mis_out_valid", bus.out_valid, 0);
        check("mis_fetch_pc", bus.fetch_pc, 32'h202);
        exp_req.push_back(32'h300); exp_req.push_back(32'h304);
        redirect(1'b0, 32'h300, 32'h0);
        @(negedge clk);
        check("mis_err_clear", bus.misalign_err, 0);
        repeat (15) @(negedge clk);
        check("mis_out_pc", bus.out_pc, 32'h300);
        check("mis_req_queue", exp_req.size(), 0);
`endif

        check("final_out_queue", exp_out.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_queue.md
Name: fetch_pc_queue

Overview:
- Parametrised next-generation instruction fetch unit: owns the program counter and issues word fetches to instruction memory over a valid/ready request channel.
- Queues returned {pc, instr} pairs in a small FIFO for decode.
- Supports absolute and PC-relative redirects (branch/jump), with flush and discard of in-flight stale fetches.
- Sits between the imem port and the decode stage.

Parameters:
- XLEN, 32, PC/address/instruction width.
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, fetch FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  1  redirect PC this cycle
- redirect_mode  in  1  0: target=redirect_base; 1: target=redirect_base+redirect_imm
- redirect_base  in  XLEN  absolute target / relative base
- redirect_imm  in  XLEN  signed offset
- imem_req_valid  out  1  fetch request valid (registered)
- imem_req_ready  in  1  imem accepts request
- imem_req_addr  out  XLEN  fetch address (registered)
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  XLEN  fetched instruction
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode consumes head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  XLEN  head instruction
- fetch_pc  out  XLEN  next PC to be requested

Behaviour:
- Reset, asynchronous, all registers:
  - pc_q=RESET_PC.
  - State IDLE.
  - imem_req_valid=0, imem_req_addr=0.
  - FIFO empty, out_valid=0, out_pc=0, out_instr=0.
- At most one outstanding request.
- States and transitions:
  - IDLE: go to REQ when FIFO count < DEPTH.
  - REQ: imem_req_valid=1, imem_req_addr=pc_q. Address is held stable until imem_req_ready. On handshake: req_pc<=pc_q, pc_q<=pc_q+4, go to WAIT.
  - WAIT: on imem_rsp_valid, push {req_pc, imem_rsp_data}. Go to REQ if post-push count < DEPTH, else IDLE.
  - KILL_REQ: request still pending but stale. On handshake go to DRAIN; pc_q is not incremented.
  - DRAIN: on imem_rsp_valid, discard the data and go to IDLE.
- imem_req_valid deasserts the cycle after handshake.
- Latency:
  - imem_req_valid rises in the 2nd cycle after reset release.
  - A response pushed in cycle N gives out_valid=1 in cycle N+1.
- FIFO pops on out_valid && out_ready.
- Full FIFO: no new request issued. Push and pop in the same cycle is allowed.
- Redirect, evaluated every cycle, highest priority:
  - pc_q <= target, and the FIFO is flushed (out_valid=0 next cycle).
  - Target arithmetic is mod 2^XLEN; bits [1:0] are forced to 0.
  - In REQ with request not accepted this cycle: go to KILL_REQ.
  - In REQ with handshake in the same cycle: go to DRAIN.
  - In WAIT with no response this cycle: go to DRAIN.
  - In WAIT with rsp_valid in the same cycle: response is discarded; go to IDLE.
  - In IDLE: go to IDLE (re-evaluated next cycle).
  - In KILL_REQ or DRAIN: update pc_q only; state is unchanged.
  - Redirect and out handshake in the same cycle: the flush wins.
- Sequential PC increment wraps mod 2^XLEN.
- fetch_pc = pc_q.
- Reset mid-transaction: state returns to IDLE. imem is also reset by the same signal, so no stale response is expected.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect whose target[1:0]!=0 sets misalign_err and loads pc_q with the unmasked target.
  - Fetch halts in IDLE: no requests while misalign_err=1.
  - Stale requests still drain normally.
  - The next redirect with an aligned target clears misalign_err and resumes fetch.
- Undefined: target bits [1:0] are silently forced to 0, and the misalign_err port is absent.

Test Plan:
- Reset release, RESET_PC=0x100, ready=1, response 1 cycle after each request, out_ready=1 -> out_pc sequence 0x100,0x104,0x108 with matching instr. imem_req_valid first high in the 2nd cycle.
- out_ready=0, DEPTH=2 -> exactly 2 requests issued, imem_req_valid stays 0, and the FIFO holds 0x100/0x104. Releasing out_ready resumes at 0x108.
- imem_req_ready=0 held 3 cycles -> imem_req_valid/addr stay stable at 0x100. Redirect absolute 0x200 during the stall -> after acceptance the 0x100 response is discarded, and the next request is 0x200.
- Redirect mode 1, base=0x1000, imm=0xFFFFFFF8 while in WAIT -> in-flight response dropped, FIFO flushed, next imem_req_addr=0xFF8.
- pc=0xFFFFFFFC sequential -> next request 0x00000000 (wrap).
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x202 -> misalign_err=1 and no requests. Then redirect to 0x300 -> misalign_err=0 and a request to 0x300.
